// File: rtl/v_bank_arbiter.sv
// Pipelined read arbiter: decodes row requests onto NBANKS interleaved banks and
// returns the captured read data in request order through a credit-protected FIFO.
module v_bank_arbiter #(
    parameter int unsigned NBANKS      = 4,
    parameter int unsigned DATA_W      = 48,
    parameter int unsigned ROW_W       = 11,
    parameter int unsigned BANK_ADDR_W = 9,
    parameter int unsigned PAGE_OFFSET = 256,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ROW_W-1:0]              rowno,
    input  logic                          page,
    output logic [NBANKS-1:0]             bank_rd_en,
    output logic [NBANKS*BANK_ADDR_W-1:0] bank_addr,
    input  logic [NBANKS*DATA_W-1:0]      bank_data,
    output logic [DATA_W-1:0]             vout,
    output logic                          vout_valid,
    input  logic                          vout_ready
);

    localparam int unsigned BSEL_W = $clog2(NBANKS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]              credits_q, credits_d;
    logic                          ready_q, ready_d;
    logic [NBANKS-1:0]             rd_en_q, rd_en_d;
    logic [NBANKS*BANK_ADDR_W-1:0] addr_q, addr_d;
    logic                          iss_vld_q, iss_vld_d;
    logic [BSEL_W-1:0]             iss_bank_q, iss_bank_d;
    logic                          tag_vld_q  [RD_LAT];
    logic [BSEL_W-1:0]             tag_bank_q [RD_LAT];
    logic [DATA_W-1:0]             mem_q      [FIFO_DEPTH];
    logic [PTR_W-1:0]              wptr_q, wptr_d;
    logic [PTR_W-1:0]              rptr_q, rptr_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          valid_q, valid_d;

    logic                          accept_c;
    logic                          pop_c;
    logic                          push_c;
    logic [BSEL_W-1:0]             dec_bank_c;
    logic [BANK_ADDR_W-1:0]        dec_addr_c;
    logic [DATA_W-1:0]             cap_data_c;

    assign accept_c = req_valid && ready_q;
    assign pop_c    = valid_q && vout_ready;
    assign push_c   = tag_vld_q[RD_LAT-1];

    assign req_ready  = ready_q;
    assign bank_rd_en = rd_en_q;
    assign bank_addr  = addr_q;
    assign vout_valid = valid_q;
    assign vout       = mem_q[rptr_q];

    // Row decode: low bits pick the bank, the rest (plus page offset) wrap into the bank address
    always_comb begin
        dec_bank_c = rowno[BSEL_W-1:0];
        dec_addr_c = BANK_ADDR_W'(rowno >> BSEL_W)
                   + (page ? BANK_ADDR_W'(PAGE_OFFSET) : BANK_ADDR_W'(0));
    end

    // Issue stage: one-hot strobe and address on the owning slice only
    always_comb begin
        rd_en_d    = '0;
        addr_d     = '0;
        iss_vld_d  = accept_c;
        iss_bank_d = dec_bank_c;
        for (int b = 0; b < NBANKS; b++) begin
            if (accept_c && (dec_bank_c == BSEL_W'(b))) begin
                rd_en_d[b] = 1'b1;
                addr_d[b*BANK_ADDR_W +: BANK_ADDR_W] = dec_addr_c;
            end
        end
    end

    // Capture mux: select the data slice of the bank named by the tail tag
    always_comb begin
        cap_data_c = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (tag_bank_q[RD_LAT-1] == BSEL_W'(b)) begin
                cap_data_c = bank_data[b*DATA_W +: DATA_W];
            end
        end
    end

    // Credits bound in-flight reads plus FIFO occupancy to FIFO_DEPTH
    always_comb begin
        credits_d = credits_q;
        case ({accept_c, pop_c})
            2'b10:   credits_d = credits_q - CNT_W'(1);
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase
        ready_d = (credits_d != '0);
    end

    // FIFO pointer and occupancy update; push and pop may coincide even when full
    always_comb begin
        wptr_d  = push_c ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop_c  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            credits_q  <= CNT_W'(FIFO_DEPTH);
            ready_q    <= 1'b1;
            rd_en_q    <= '0;
            addr_q     <= '0;
            iss_vld_q  <= 1'b0;
            iss_bank_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            ready_q    <= ready_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            iss_vld_q  <= iss_vld_d;
            iss_bank_q <= iss_bank_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
        end
    end

    // Tag pipeline tracks the bank read latency; it never stalls
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= 1'b0;
                tag_bank_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0]  <= iss_vld_q;
            tag_bank_q[0] <= iss_bank_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_bank_q[i] <= tag_bank_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wptr_q] <= cap_data_c;
        end
    end

endmodule

// File: tb/tb_v_bank_arbiter.sv
// Randomised bench for v_bank_arbiter: a queue-based model of accepted requests
// predicts strobes, handshake readiness, output timing and data order every cycle.
module tb_v_bank_arbiter;

    localparam int unsigned NB    = 4;
    localparam int unsigned DW    = 48;
    localparam int unsigned RW    = 11;
    localparam int unsigned AW    = 9;
    localparam int unsigned POFF  = 256;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 3;

    logic              clock;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic [RW-1:0]     rowno;
    logic              page;
    logic [NB-1:0]     bank_rd_en;
    logic [NB*AW-1:0]  bank_addr;
    logic [NB*DW-1:0]  bank_data;
    logic [DW-1:0]     vout;
    logic              vout_valid;
    logic              vout_ready;

    int                n_checks;
    int                n_errors;
    int                cyc;

    logic [DW-1:0]     bankmem [NB][1 << AW];
    logic [DW-1:0]     exp_q [$];
    int                avail_q [$];
    logic [NB-1:0]     exp_en;
    logic [NB*AW-1:0]  exp_addr;

    v_bank_arbiter dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .rowno      (rowno),
        .page       (page),
        .bank_rd_en (bank_rd_en),
        .bank_addr  (bank_addr),
        .bank_data  (bank_data),
        .vout       (vout),
        .vout_valid (vout_valid),
        .vout_ready (vout_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bank memories: one-cycle read on strobe, random garbage otherwise
    always @(posedge clock) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_rd_en[b])
                bank_data[b*DW +: DW] <= bankmem[b][bank_addr[b*AW +: AW]];
            else
                bank_data[b*DW +: DW] <= DW'({$urandom(), $urandom()});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model
    task automatic cycle(input logic v, input logic [RW-1:0] r, input logic p, input logic rdy);
        logic mr, mv, acc, pp;
        int   b, a;
        @(negedge clock);
        mr = (exp_q.size() < DEPTH);
        mv = (exp_q.size() > 0) && (avail_q[0] <= cyc);
        chk("req_ready", 64'(req_ready), 64'(mr));
        chk("vout_valid", 64'(vout_valid), 64'(mv));
        if (mv) chk("vout", 64'(vout), 64'(exp_q[0]));
        chk("bank_rd_en", 64'(bank_rd_en), 64'(exp_en));
        chk("bank_addr", 64'(bank_addr), 64'(exp_addr));
        req_valid  = v;
        rowno      = r;
        page       = p;
        vout_ready = rdy;
        acc = v && mr;
        pp  = mv && rdy;
        if (pp) begin
            void'(exp_q.pop_front());
            void'(avail_q.pop_front());
        end
        exp_en   = '0;
        exp_addr = '0;
        if (acc) begin
            b = int'(r) % NB;
            a = (int'(r) / NB + (p ? POFF : 0)) % (1 << AW);
            exp_en[b] = 1'b1;
            exp_addr[b*AW +: AW] = a[AW-1:0];
            exp_q.push_back(bankmem[b][a]);
            avail_q.push_back(cyc + LAT);
        end
        @(posedge clock);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        rowno      = '0;
        page       = 1'b0;
        vout_ready = 1'b0;
        bank_data  = '0;
        exp_en     = '0;
        exp_addr   = '0;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < (1 << AW); a++)
                bankmem[b][a] = DW'({$urandom(), $urandom()});
        bankmem[1][1] = 48'hA5;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rd_en", 64'(bank_rd_en), 64'd0);
        chk("rst_addr", 64'(bank_addr), 64'd0);
        chk("rst_vout", 64'(vout), 64'd0);
        chk("rst_vout_valid", 64'(vout_valid), 64'd0);
        resetn = 1'b1;

        // Decode and page wrap
        cycle(1'b1, 11'h005, 1'b0, 1'b1);
        idle(4);
        cycle(1'b1, 11'h7FF, 1'b1, 1'b1);
        cycle(1'b1, 11'h004, 1'b1, 1'b1);
        idle(5);

        // Streaming rows 0..15
        for (int i = 0; i < 16; i++) cycle(1'b1, RW'(i), 1'b0, 1'b1);
        idle(6);

        // Backpressure, single pop, then drain
        for (int i = 0; i < 8; i++) cycle(1'b1, RW'($urandom), 1'($urandom), 1'b0);
        cycle(1'b1, RW'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, RW'($urandom), 1'($urandom), 1'b0);
        idle(8);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 3) != 0), RW'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0));
        idle(8);

        // Mid-flight reset after two accepts
        cycle(1'b1, RW'($urandom), 1'($urandom), 1'b1);
        cycle(1'b1, RW'($urandom), 1'($urandom), 1'b1);
        @(negedge clock);
        resetn    = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("mrst_req_ready", 64'(req_ready), 64'd1);
        chk("mrst_rd_en", 64'(bank_rd_en), 64'd0);
        chk("mrst_addr", 64'(bank_addr), 64'd0);
        chk("mrst_vout", 64'(vout), 64'd0);
        chk("mrst_vout_valid", 64'(vout_valid), 64'd0);
        exp_q.delete();
        avail_q.delete();
        exp_en   = '0;
        exp_addr = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        cyc++;
        idle(4);
        cycle(1'b1, 11'h005, 1'b0, 1'b1);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
